fpadd_rr_sched: RTL and testbench
=================================

// Module: fpadd_rr_sched
// PURPOSE
//  Shares one multi-cycle fpadd unit among NREQ requesters. Accepts operand pairs over per-port
//  valid/ready, picks one round-robin, pulses the adder's start, waits for done (with timeout),
//  returns the sum to the winning port over valid/ready. Sits between client FSMs and the adder.
// PARAMETERS
//  NREQ     4   number of requester ports (2..8)
//  TMO_CYC  64  cycles to wait for fa_done before aborting the op with rsp_err=1
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  reset      in   1        reset, synchronous, active-high
//  req_valid  in   NREQ     port i has operand pair on req_a/req_b slice i
//  req_a      in   32*NREQ  IEEE-754 single operand A, slice i = [32*i+31:32*i]
//  req_b      in   32*NREQ  operand B, same slicing
//  req_ready  out  NREQ     one-hot grant; pair taken when req_valid[i]&req_ready[i]
//  rsp_valid  out  NREQ     one-hot; result for port i on rsp_sum/rsp_err
//  rsp_ready  in   NREQ     port i accepts the result
//  rsp_sum    out  32       adder result (0 on timeout)
//  rsp_err    out  1        1 = op timed out
//  fa_start   out  1        start pulse to adder
//  fa_a       out  32       operand A to adder (held stable from ISSUE through WAIT)
//  fa_b       out  32       operand B to adder
//  fa_sum     in   32       adder result
//  fa_done    in   1        adder done level (sticky until next start)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_err=0, fa_start=0, fa_a=fa_b=0,
//   rr_ptr=0, tmo_cnt=0. Reset mid-op abandons the op; no response issued.
//  IDLE: if any req_valid, grant first set bit at/after rr_ptr (wrap mod NREQ): req_ready[g]=1
//   for exactly one cycle (combinational from state+valid), latch A/B to fa_a/fa_b, grant idx g;
//   -> ISSUE. rr_ptr <= (g+1) mod NREQ. No valid: stay, req_ready=0.
//  ISSUE (1 cyc): fa_start=1 -> WAIT; tmo_cnt<=0.
//  WAIT: fa_start=0. fa_done ignored on the first WAIT cycle (stale level from prior op). From
//   2nd cycle on: fa_done=1 -> latch rsp_sum<=fa_sum, rsp_err<=0 -> RESP. tmo_cnt increments;
//   tmo_cnt==TMO_CYC-1 without done -> rsp_sum<=0, rsp_err<=1 -> RESP. Done on the timeout
//   cycle wins (no error).
//  RESP: rsp_valid[g]=1, rsp_sum/rsp_err stable; rsp_ready[g]=1 -> rsp_valid=0, -> IDLE.
//   rsp_ready of other ports ignored. No new grant while in RESP (one op in flight).
//  Latency: grant->start 1 cyc; start->rsp_valid = adder latency + 1 cyc; back-to-back ops
//   from IDLE after response handshake, min 1 idle cycle between rsp accept and next grant.
//  Fairness: port granted goes to lowest priority; with all ports valid grants cycle 0,1,..,N-1.
//  Requester contract: req_valid/operands held until granted; dropping valid before grant is
//   legal (no grant issued). Only one req_ready bit ever high; never asserted outside IDLE.
//  Zero-width cases: NREQ==1 degenerates to pass-through, rr_ptr fixed 0.
// STRUCTURE
//  fpadd_pkg: FP_W=32, state enum {IDLE,ISSUE,WAIT,RESP} (2-bit), IDX_W=$clog2(NREQ).
//  Sub-module rr_arbiter #(N): req vector + ptr in -> one-hot grant + index out, combinational.
//  Top: FSM, operand/result regs, timeout counter, rr_ptr reg.
// TESTING (bench instantiates real fpadd behind this block)
//  Single: port0 a=0x3F800000 b=0x40000000 -> one fa_start pulse, rsp_valid=0001, sum=0x40400000.
//  All 4 valid simultaneously, rsp_ready tied 1 -> grant order 0,1,2,3,0; each sum to right port.
//  Stale done: 2 back-to-back ops port2 -> 2nd rsp_sum from 2nd op, not latched from old done.
//  Stub adder never asserts fa_done -> rsp_err=1, rsp_sum=0 after TMO_CYC cycles in WAIT.
//  Backpressure: rsp_ready low 10 cycles -> rsp_valid/rsp_sum stable, no new req_ready.
//  reset during WAIT -> all outputs reset value next cycle; next req served normally.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared types and constants for the fpadd round-robin scheduler slice.
package fpadd_pkg;

   localparam int FP_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Index width that stays at least one bit wide so a single-port build still has a legal vector.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpadd_rr_sched_arb.sv
// Combinational round-robin arbiter: first requesting port at or after the pointer wins.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_cand;

   // Walk the ports starting at the pointer, wrapping modulo N, and keep the first requester.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % N);
         if (!o_any && i_req[w_cand]) begin
            o_any           = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Shares one multi-cycle fpadd unit among NREQ requesters with round-robin grants and a done timeout.
module fpadd_rr_sched
   import fpadd_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TMO_CYC = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      i_req_valid,
   input  logic [FP_W*NREQ-1:0] i_req_a,
   input  logic [FP_W*NREQ-1:0] i_req_b,
   output logic [NREQ-1:0]      o_req_ready,
   output logic [NREQ-1:0]      o_rsp_valid,
   input  logic [NREQ-1:0]      i_rsp_ready,
   output logic [FP_W-1:0]      o_rsp_sum,
   output logic                 o_rsp_err,
   output logic                 o_fa_start,
   output logic [FP_W-1:0]      o_fa_a,
   output logic [FP_W-1:0]      o_fa_b,
   input  logic [FP_W-1:0]      i_fa_sum,
   input  logic                 i_fa_done
);

   localparam int IDX_W = idxWidth(NREQ);
   localparam int TMO_W = $clog2(TMO_CYC) + 1;

   state_t           r_state;
   state_t           w_nextState;
   logic [IDX_W-1:0] r_rrPtr;
   logic [IDX_W-1:0] r_grantIdx;
   logic [TMO_W-1:0] r_tmoCnt;
   logic [FP_W-1:0]  r_faA;
   logic [FP_W-1:0]  r_faB;
   logic [FP_W-1:0]  r_rspSum;
   logic             r_rspErr;

   logic [NREQ-1:0]  w_arbGrant;
   logic [IDX_W-1:0] w_arbIdx;
   logic             w_arbAny;
   logic [IDX_W-1:0] w_nextPtr;
   logic             w_doneSeen;
   logic             w_timeout;

   rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_rrPtr),
      .o_grant (w_arbGrant),
      .o_idx   (w_arbIdx),
      .o_any   (w_arbAny)
   );

   // The first WAIT cycle has a zero count, so a done level left over from the previous op is ignored there.
   assign w_doneSeen = (r_tmoCnt != '0) && i_fa_done;
   assign w_timeout  = (r_tmoCnt == TMO_W'(TMO_CYC - 1));
   assign w_nextPtr  = (w_arbIdx == IDX_W'(NREQ - 1)) ? '0 : (w_arbIdx + IDX_W'(1));

   assign o_rsp_sum = r_rspSum;
   assign o_rsp_err = r_rspErr;
   assign o_fa_a    = r_faA;
   assign o_fa_b    = r_faB;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Next-state logic: one op in flight, RESP only leaves on the winner's own rsp_ready.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_arbAny) w_nextState = ISSUE;
         ISSUE:   w_nextState = WAIT;
         WAIT:    if (w_doneSeen || w_timeout) w_nextState = RESP;
         RESP:    if (i_rsp_ready[r_grantIdx]) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Output decode: grant is combinational in IDLE, start is a one-cycle pulse, response is one-hot to the winner.
   always_comb begin
      o_req_ready = '0;
      o_rsp_valid = '0;
      o_fa_start  = 1'b0;
      case (r_state)
         IDLE:    o_req_ready = w_arbGrant;
         ISSUE:   o_fa_start = 1'b1;
         RESP:    o_rsp_valid[r_grantIdx] = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture on grant, timeout counting in WAIT, result or error capture on exit from WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rrPtr    <= '0;
         r_grantIdx <= '0;
         r_tmoCnt   <= '0;
         r_faA      <= '0;
         r_faB      <= '0;
         r_rspSum   <= '0;
         r_rspErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_arbAny) begin
                  r_faA      <= i_req_a[FP_W*w_arbIdx +: FP_W];
                  r_faB      <= i_req_b[FP_W*w_arbIdx +: FP_W];
                  r_grantIdx <= w_arbIdx;
                  r_rrPtr    <= w_nextPtr;
               end
            end
            ISSUE: r_tmoCnt <= '0;
            WAIT: begin
               if (w_doneSeen) begin
                  r_rspSum <= i_fa_sum;
                  r_rspErr <= 1'b0;
               end else if (w_timeout) begin
                  r_rspSum <= '0;
                  r_rspErr <= 1'b1;
               end else begin
                  r_tmoCnt <= r_tmoCnt + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpadd_rr_sched.sv
// Self-checking bench: behavioural adder, cycle-level scheduler model, directed and random traffic.
module tb_fpadd_rr_sched;

   localparam int NREQ    = 4;
   localparam int TMO_CYC = 64;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [NREQ-1:0]      i_req_valid = '0;
   logic [32*NREQ-1:0]   i_req_a = '0;
   logic [32*NREQ-1:0]   i_req_b = '0;
   logic [NREQ-1:0]      i_rsp_ready = '1;
   logic [31:0]          i_fa_sum = '0;
   logic                 i_fa_done = 1'b0;
   logic [NREQ-1:0]      o_req_ready;
   logic [NREQ-1:0]      o_rsp_valid;
   logic [31:0]          o_rsp_sum;
   logic                 o_rsp_err;
   logic                 o_fa_start;
   logic [31:0]          o_fa_a;
   logic [31:0]          o_fa_b;

   int checks = 0;
   int errors = 0;

   fpadd_rr_sched #(.NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_valid (i_req_valid),
      .i_req_a     (i_req_a),
      .i_req_b     (i_req_b),
      .o_req_ready (o_req_ready),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_sum   (o_rsp_sum),
      .o_rsp_err   (o_rsp_err),
      .o_fa_start  (o_fa_start),
      .o_fa_a      (o_fa_a),
      .o_fa_b      (o_fa_b),
      .i_fa_sum    (i_fa_sum),
      .i_fa_done   (i_fa_done)
   );

   always #5 clk = ~clk;

   // Exact float helpers for non-negative integers below 2^24.
   function automatic int unsigned f2i(input logic [31:0] f);
      int e;
      logic [31:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]);
      m = {8'd0, 1'b1, f[22:0]};
      return m >> (150 - e);
   endfunction

   function automatic logic [31:0] i2f(input int unsigned v);
      int p;
      logic [31:0] sh;
      if (v == 0) return 32'd0;
      p = 0;
      for (int i = 0; i < 32; i++) if (v[i]) p = i;
      sh = v << (23 - p);
      return {1'b0, 8'(127 + p), sh[22:0]};
   endfunction

   function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
      return i2f(f2i(a) + f2i(b));
   endfunction

   function automatic int pickPort(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   // Scheduler model state.
   int          cyc = 0;
   logic        mBusy = 1'b0;
   logic        grantPending = 1'b0;
   logic        acceptPending = 1'b0;
   logic        startSeen = 1'b0;
   int          mPtr = 0;
   int          curPort = 0;
   logic [31:0] curA, curB, curSum;
   logic        curHang = 1'b0;
   int          curLat = 2;
   int          grantCycle = -100;
   int          expRespCycle = 0;
   logic        forceHang = 1'b0;
   int          grantLog[$];
   int          startPulses = 0;
   logic [31:0] lastRspSum = '0;
   logic        lastRspErr = 1'b0;

   // Staged requester activity, applied just after a rising edge.
   logic [NREQ-1:0] stageValid = '0;
   logic [31:0]     stageA [NREQ];
   logic [31:0]     stageB [NREQ];
   logic [NREQ-1:0] rdyStage = '1;

   // Behavioural adder: done stays high until the cycle after the next start, then rises after curLat edges.
   logic        adderBusy = 1'b0;
   logic        adderClr = 1'b0;
   logic        adderHang = 1'b0;
   int          adderCnt = 0;
   logic [31:0] adderA = '0, adderB = '0;
   always @(posedge clk) begin
      if (o_fa_start) begin
         adderBusy <= 1'b1;
         adderClr  <= 1'b1;
         adderCnt  <= curLat;
         adderHang <= curHang;
         adderA    <= o_fa_a;
         adderB    <= o_fa_b;
      end else begin
         if (adderClr) begin
            i_fa_done <= 1'b0;
            adderClr  <= 1'b0;
         end
         if (adderBusy && !adderHang) begin
            if (adderCnt <= 1) begin
               i_fa_done <= 1'b1;
               i_fa_sum  <= fpAdd(adderA, adderB);
               adderBusy <= 1'b0;
            end else begin
               adderCnt <= adderCnt - 1;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input int port, input int unsigned a, input int unsigned b);
      stageValid[port] = 1'b1;
      stageA[port]     = i2f(a);
      stageB[port]     = i2f(b);
   endtask

   // One clock: apply staged inputs after the edge, then check every output against the model mid-cycle.
   task automatic tick();
      logic [NREQ-1:0] expReady;
      logic [NREQ-1:0] expRsp;
      int g;
      @(posedge clk);
      #1;
      cyc++;
      if (grantPending) begin
         mBusy = 1'b1;
         i_req_valid[curPort] = 1'b0;
         grantPending = 1'b0;
      end
      if (acceptPending) begin
         mBusy = 1'b0;
         startSeen = 1'b0;
         acceptPending = 1'b0;
      end
      i_rsp_ready = rdyStage;
      for (int p = 0; p < NREQ; p++) begin
         if (stageValid[p] && !i_req_valid[p]) begin
            i_req_valid[p]     = 1'b1;
            i_req_a[32*p +: 32] = stageA[p];
            i_req_b[32*p +: 32] = stageB[p];
            stageValid[p]      = 1'b0;
         end
      end
      @(negedge clk);
      if (o_fa_start) startPulses++;
      expReady = '0;
      g = mBusy ? -1 : pickPort(i_req_valid, mPtr);
      if (g >= 0) expReady[g] = 1'b1;
      checkOutput("req_ready", 32'(o_req_ready), 32'(expReady));
      if (g >= 0) begin
         curPort    = g;
         curA       = i_req_a[32*g +: 32];
         curB       = i_req_b[32*g +: 32];
         curHang    = forceHang;
         curLat     = $urandom_range(2, 6);
         curSum     = curHang ? 32'd0 : fpAdd(curA, curB);
         grantCycle = cyc;
         mPtr       = (g + 1) % NREQ;
         grantLog.push_back(g);
         grantPending = 1'b1;
      end
      checkOutput("fa_start", 32'(o_fa_start), 32'(mBusy && cyc == grantCycle + 1));
      if (mBusy && cyc == grantCycle + 1) begin
         checkOutput("fa_a", o_fa_a, curA);
         checkOutput("fa_b", o_fa_b, curB);
         startSeen    = 1'b1;
         expRespCycle = curHang ? cyc + TMO_CYC + 1 : cyc + curLat + 2;
      end
      expRsp = '0;
      if (mBusy && startSeen && cyc >= expRespCycle) expRsp[curPort] = 1'b1;
      checkOutput("rsp_valid", 32'(o_rsp_valid), 32'(expRsp));
      if (expRsp != '0) begin
         checkOutput("rsp_sum", o_rsp_sum, curSum);
         checkOutput("rsp_err", 32'(o_rsp_err), 32'(curHang));
         if (i_rsp_ready[curPort]) begin
            acceptPending = 1'b1;
            lastRspSum    = o_rsp_sum;
            lastRspErr    = o_rsp_err;
         end
      end
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((mBusy || grantPending || acceptPending || i_req_valid != '0 || stageValid != '0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) checkOutput("drain_budget", 32'(n), 32'(budget - 1));
   endtask

   task automatic checkResetState();
      checkOutput("rst_req_ready", 32'(o_req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      checkOutput("rst_rsp_sum", o_rsp_sum, 32'd0);
      checkOutput("rst_rsp_err", 32'(o_rsp_err), 32'd0);
      checkOutput("rst_fa_start", 32'(o_fa_start), 32'd0);
      checkOutput("rst_fa_a", o_fa_a, 32'd0);
      checkOutput("rst_fa_b", o_fa_b, 32'd0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      i_req_valid = '0;
      stageValid = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mBusy = 1'b0;
      grantPending = 1'b0;
      acceptPending = 1'b0;
      startSeen = 1'b0;
      mPtr = 0;
      grantCycle = -100;
      @(negedge clk);
      checkResetState();
   endtask

   initial begin
      int base;
      int n;
      doReset();

      // Single op on port 0: 1.0 + 2.0.
      base = startPulses;
      applyStimulus(0, 1, 2);
      waitDrain(40);
      checkOutput("single_port", 32'(grantLog[$]), 32'd0);
      checkOutput("single_starts", 32'(startPulses - base), 32'd1);
      checkOutput("single_sum", lastRspSum, 32'h4040_0000);

      // All ports at once from a fresh pointer, then port 0 again.
      doReset();
      base = grantLog.size();
      for (int p = 0; p < NREQ; p++) applyStimulus(p, 10 * (p + 1), p + 7);
      waitDrain(200);
      applyStimulus(0, 5, 6);
      waitDrain(40);
      for (int i = 0; i < 5; i++) checkOutput("rr_order", 32'(grantLog[base + i]), 32'(i % NREQ));

      // Two back-to-back ops on port 2: the second result must not come from the stale done level.
      applyStimulus(2, 100, 200);
      waitDrain(40);
      applyStimulus(2, 7, 9);
      waitDrain(40);
      checkOutput("stale_sum", lastRspSum, i2f(16));

      // Adder that never completes: error response with zero sum.
      forceHang = 1'b1;
      applyStimulus(1, 3, 4);
      waitDrain(200);
      forceHang = 1'b0;
      checkOutput("tmo_err", 32'(lastRspErr), 32'd1);
      checkOutput("tmo_sum", lastRspSum, 32'd0);

      // Backpressure on port 3 while port 0 keeps requesting.
      rdyStage = 4'b0111;
      applyStimulus(3, 1000, 24);
      applyStimulus(0, 2, 2);
      n = 0;
      while (o_rsp_valid == '0 && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) checkOutput("bp_wait", 32'(n), 32'd59);
      repeat (10) tick();
      checkOutput("bp_valid", 32'(o_rsp_valid), 32'b1000);
      checkOutput("bp_sum", o_rsp_sum, i2f(1024));
      checkOutput("bp_no_grant", 32'(o_req_ready), 32'd0);
      rdyStage = '1;
      waitDrain(60);
      checkOutput("bp_next_port", 32'(grantLog[$]), 32'd0);

      // Reset while waiting on the adder, then a normal op.
      forceHang = 1'b1;
      applyStimulus(1, 11, 12);
      n = 0;
      while (!startSeen && n < 20) begin
         tick();
         n++;
      end
      repeat (3) tick();
      doReset();
      forceHang = 1'b0;
      applyStimulus(3, 50, 60);
      waitDrain(40);
      checkOutput("post_reset_port", 32'(grantLog[$]), 32'd3);
      checkOutput("post_reset_sum", lastRspSum, i2f(110));

      // Random traffic with random response backpressure and occasional hung adds.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NREQ; p++)
            if (!stageValid[p] && $urandom_range(0, 3) == 0)
               applyStimulus(p, $urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
         rdyStage  = NREQ'($urandom);
         forceHang = ($urandom_range(0, 15) == 0);
         tick();
      end
      rdyStage  = '1;
      forceHang = 1'b0;
      waitDrain(600);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
